// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: ALU op codes, RV32I field constants and issue FSM states      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00011;
  localparam logic [4:0] ALU_AND   = 5'b01010;
  localparam logic [4:0] ALU_OR    = 5'b01100;
  localparam logic [4:0] ALU_XOR   = 5'b01101;
  localparam logic [4:0] ALU_SLL   = 5'b01110;
  localparam logic [4:0] ALU_SRL   = 5'b01111;
  localparam logic [4:0] ALU_SRA   = 5'b10000;
  localparam logic [4:0] ALU_LUI   = 5'b11001;
  localparam logic [4:0] ALU_AUIPC = 5'b11010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_decode: combinational RV32I decode into ALU op and operands  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] imm,
  output logic [4:0]       rd,
  output logic             use_imm,
  output logic             is_shift,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  always_comb begin
    op       = ALU_ADD;
    imm      = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    use_imm  = 1'b0;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        // Only base and alternate funct7 exist here; anything else (M-ext) is rejected
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_ALT) op = ALU_SUB;
            else illegal = (funct7 != F7_BASE);
          end
          F3_SLL: begin op = ALU_SLL; is_shift = 1'b1; illegal = (funct7 != F7_BASE); end
          F3_XOR: begin op = ALU_XOR; illegal = (funct7 != F7_BASE); end
          F3_OR:  begin op = ALU_OR;  illegal = (funct7 != F7_BASE); end
          F3_AND: begin op = ALU_AND; illegal = (funct7 != F7_BASE); end
          F3_SR: begin
            is_shift = 1'b1;
            if (funct7 == F7_BASE) op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD: op = ALU_ADD;
          F3_XOR: op = ALU_XOR;
          F3_OR:  op = ALU_OR;
          F3_AND: op = ALU_AND;
          F3_SLL: begin op = ALU_SLL; is_shift = 1'b1; illegal = (funct7 != F7_BASE); end
          F3_SR: begin
            is_shift = 1'b1;
            if (funct7 == F7_BASE) op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op      = ALU_LUI;
        imm     = {{(WIDTH-20){1'b0}}, instr[31:12]};
        use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        op      = ALU_AUIPC;
        imm     = {{(WIDTH-20){1'b0}}, instr[31:12]};
        use_imm = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue: decode/issue stage feeding a shift-by-1 ALU; optional WAIT  |
// | watchdog enabled by ALU_ISSUE_TIMEOUT_EN.   Revision: 1.0              |
// +----------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
`ifdef ALU_ISSUE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [4:0]       rd_q, rd_d, cnt_q, cnt_d;
  logic             alu_en_q, alu_en_d, ready_q, ready_d;
  logic             wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, illegal_q, illegal_d;

  logic [4:0]       dec_op, dec_rd, shamt;
  logic [WIDTH-1:0] dec_imm;
  logic             dec_use_imm, dec_is_shift, dec_illegal;

  alu_issue_decode #(.WIDTH(WIDTH)) u_decode (
    .instr    (instr_q),
    .op       (dec_op),
    .imm      (dec_imm),
    .rd       (dec_rd),
    .use_imm  (dec_use_imm),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  assign shamt = dec_use_imm ? dec_imm[4:0] : rs2_data[4:0];

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    alu_en_d   = 1'b0;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    illegal_d  = 1'b0;
    wb_data_d  = wb_data_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          pc_d    = pc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rd_d = dec_rd;
        if (dec_illegal) begin
          state_d    = S_WB;
          wb_valid_d = 1'b1;
          illegal_d  = 1'b1;
        end else begin
          state_d  = S_ISSUE;
          alu_en_d = 1'b1;
          op_d     = OP_W'(dec_op);
          a_d      = rs1_data;
          b_d      = dec_use_imm ? dec_imm : rs2_data;
          cnt_d    = 5'd1;
          if (dec_op == ALU_LUI) begin
            a_d = dec_imm;
            b_d = '0;
          end else if (dec_op == ALU_AUIPC) begin
            a_d = pc_q;
            b_d = dec_imm;
          end else if (dec_is_shift) begin
            // A zero shift becomes a pass-through add so the result equals a
            if (shamt == 5'd0) begin
              op_d = OP_W'(ALU_ADD);
              b_d  = '0;
            end else begin
              cnt_d = shamt;
              b_d   = WIDTH'(1);
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      S_WAIT: begin
        if (alu_valid) begin
          if (cnt_q > 5'd1) begin
            cnt_d    = cnt_q - 5'd1;
            a_d      = alu_result;
            alu_en_d = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            cnt_d      = 5'd0;
            wb_data_d  = alu_result;
            wb_valid_d = 1'b1;
            wb_we_d    = (rd_q != 5'd0);
            state_d    = S_WB;
          end
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d      = 5'd0;
          wb_valid_d = 1'b1;
          illegal_d  = 1'b1;
          state_d    = S_WB;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      pc_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      alu_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
      wb_data_q  <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      alu_en_q   <= alu_en_d;
      ready_q    <= ready_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      illegal_q  <= illegal_d;
      wb_data_q  <= wb_data_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign instr_ready = ready_q;
  assign rs1_addr    = instr_q[19:15];
  assign rs2_addr    = instr_q[24:20];
  assign alu_en      = alu_en_q;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue: directed bench for alu_issue with a shift-by-1 ALU model |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic        wb_valid, wb_we, illegal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [31:0] regs [0:31];
  logic        resp_en = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  int          lat, n_iss, e0;
  logic [4:0]  iss_op [0:7];
  logic [31:0] iss_a [0:7];
  logic [31:0] iss_b [0:7];
  logic [31:0] r_data;
  logic [4:0]  r_rd;
  logic        r_we, r_ill, ready_after;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_en(alu_en), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    alu_valid <= alu_en & resp_en;
    case (alu_op)
      5'b00001: alu_result <= alu_a + alu_b;
      5'b00011: alu_result <= alu_a - alu_b;
      5'b01010: alu_result <= alu_a & alu_b;
      5'b01100: alu_result <= alu_a | alu_b;
      5'b01101: alu_result <= alu_a ^ alu_b;
      5'b01110: alu_result <= alu_a << 1;
      5'b01111: alu_result <= alu_a >> 1;
      5'b10000: alu_result <= $unsigned($signed(alu_a) >>> 1);
      5'b11001: alu_result <= alu_a << 12;
      5'b11010: alu_result <= alu_a + (alu_b << 12);
      default:  alu_result <= 32'h0;
    endcase
  end

  // Offers one instruction and follows it to writeback or until bound negedges pass
  task automatic run(input logic [31:0] ins, input logic [31:0] p, input int bound);
    int k;
    k = 0; lat = -1; n_iss = 0;
    while (!instr_ready && k < 20) begin @(negedge clk); k++; end
    instr = ins; pc = p; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; e0 = cyc; ready_after = instr_ready;
    for (int i = 0; i < bound; i++) begin
      if (alu_en) begin
        if (n_iss < 8) begin iss_op[n_iss] = alu_op; iss_a[n_iss] = alu_a; iss_b[n_iss] = alu_b; end
        n_iss++;
      end
      if (wb_valid) begin
        lat = cyc - e0; r_data = wb_data; r_rd = wb_rd; r_we = wb_we; r_ill = illegal;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
    checks++; if ({alu_en, wb_valid, wb_we, illegal} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {alu_en, wb_valid, wb_we, illegal}); end
    checks++; if ({alu_op, alu_a, alu_b, wb_data, wb_rd, rs1_addr} !== '0) begin errors++; $display("FAIL rst_buses got nonzero exp 0"); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", instr_ready); end
  endtask

  task automatic test_addi();
    regs[1] = 32'd10;
    run({12'hFFD, 5'd1, 3'b000, 5'd5, 7'b0010011}, 32'h0, 40);
    checks++; if (ready_after !== 1'b0) begin errors++; $display("FAIL addi_busy_ready got %b exp 0", ready_after); end
    checks++; if (n_iss !== 1) begin errors++; $display("FAIL addi_issues got %0d exp 1", n_iss); end
    checks++; if (iss_op[0] !== 5'b00001 || iss_a[0] !== 32'd10 || iss_b[0] !== 32'hFFFFFFFD) begin errors++; $display("FAIL addi_operands got op %b a %h b %h exp 00001 0000000a fffffffd", iss_op[0], iss_a[0], iss_b[0]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL addi_latency got %0d exp 3", lat); end
    checks++; if (r_data !== 32'd7 || r_rd !== 5'd5 || r_we !== 1'b1 || r_ill !== 1'b0) begin errors++; $display("FAIL addi_wb got data %0d rd %0d we %b ill %b exp 7 5 1 0", r_data, r_rd, r_we, r_ill); end
  endtask

  task automatic test_shift();
    regs[3] = 32'd1;
    run({7'b0000000, 5'd3, 5'd3, 3'b001, 5'd2, 7'b0010011}, 32'h0, 40);
    checks++; if (n_iss !== 3 || iss_op[0] !== 5'b01110 || iss_op[2] !== 5'b01110) begin errors++; $display("FAIL slli_issues got %0d op %b exp 3 01110", n_iss, iss_op[0]); end
    checks++; if (iss_a[1] !== 32'd2 || iss_a[2] !== 32'd4) begin errors++; $display("FAIL slli_feedback got %h %h exp 2 4", iss_a[1], iss_a[2]); end
    checks++; if (lat !== 7 || r_data !== 32'd8 || r_rd !== 5'd2) begin errors++; $display("FAIL slli_wb got lat %0d data %0d rd %0d exp 7 8 2", lat, r_data, r_rd); end
    regs[9] = 32'h80000000; regs[10] = 32'd2;
    run({7'b0100000, 5'd10, 5'd9, 3'b101, 5'd8, 7'b0110011}, 32'h0, 40);
    checks++; if (n_iss !== 2 || iss_op[0] !== 5'b10000 || lat !== 5 || r_data !== 32'hE0000000) begin errors++; $display("FAIL sra_wb got n %0d op %b lat %0d data %h exp 2 10000 5 e0000000", n_iss, iss_op[0], lat, r_data); end
    regs[6] = 32'h12345678; regs[7] = 32'd32;
    run({7'b0000000, 5'd7, 5'd6, 3'b001, 5'd4, 7'b0110011}, 32'h0, 40);
    checks++; if (n_iss !== 1 || iss_op[0] !== 5'b00001 || iss_b[0] !== 32'h0) begin errors++; $display("FAIL sll0_issue got n %0d op %b b %h exp 1 00001 0", n_iss, iss_op[0], iss_b[0]); end
    checks++; if (lat !== 3 || r_data !== 32'h12345678) begin errors++; $display("FAIL sll0_wb got lat %0d data %h exp 3 12345678", lat, r_data); end
  endtask

  task automatic test_upper();
    run({20'h12345, 5'd11, 7'b0110111}, 32'h0, 40);
    checks++; if (iss_op[0] !== 5'b11001 || iss_a[0] !== 32'h00012345 || r_data !== 32'h12345000 || lat !== 3) begin errors++; $display("FAIL lui got op %b a %h data %h lat %0d", iss_op[0], iss_a[0], r_data, lat); end
    run({20'h00001, 5'd12, 7'b0010111}, 32'h100, 40);
    checks++; if (iss_op[0] !== 5'b11010 || iss_a[0] !== 32'h100 || iss_b[0] !== 32'h1 || r_data !== 32'h1100) begin errors++; $display("FAIL auipc got op %b a %h b %h data %h", iss_op[0], iss_a[0], iss_b[0], r_data); end
  endtask

  task automatic test_x0_illegal();
    regs[2] = 32'd5;
    run({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011}, 32'h0, 40);
    checks++; if (lat !== 3 || r_we !== 1'b0 || r_rd !== 5'd0 || r_data !== 32'd15) begin errors++; $display("FAIL add_x0 got lat %0d we %b rd %0d data %0d exp 3 0 0 15", lat, r_we, r_rd, r_data); end
    run({12'd5, 5'd2, 3'b010, 5'd1, 7'b0010011}, 32'h0, 40);
    checks++; if (lat !== 1 || r_ill !== 1'b1 || r_we !== 1'b0 || n_iss !== 0) begin errors++; $display("FAIL slti got lat %0d ill %b we %b issues %0d exp 1 1 0 0", lat, r_ill, r_we, n_iss); end
    run({7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}, 32'h0, 40);
    checks++; if (lat !== 1 || r_ill !== 1'b1 || n_iss !== 0) begin errors++; $display("FAIL mul got lat %0d ill %b issues %0d exp 1 1 0", lat, r_ill, n_iss); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    n = 0; seen = 0;
    regs[2] = 32'hF0;
    while (!instr_ready) @(negedge clk);
    instr = {7'b0, 5'd5, 5'd2, 3'b101, 5'd1, 7'b0010011}; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (alu_en) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL rmid_reach got %0d issues exp 3", n); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (wb_valid) seen++;
    checks++; if ({alu_en, wb_valid, instr_ready, illegal} !== 4'b0 || alu_a !== 32'h0 || alu_op !== 5'h0) begin errors++; $display("FAIL rmid_outputs got en %b wbv %b rdy %b a %h exp all 0", alu_en, wb_valid, instr_ready, alu_a); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", instr_ready); end
    repeat (12) begin if (wb_valid) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_wb got %0d strobes exp 0", seen); end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    regs[1] = 32'd1; regs[2] = 32'd2;
`ifdef ALU_ISSUE_TIMEOUT_EN
    run({7'b0, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011}, 32'h0, 120);
    checks++; if (lat !== 18 || r_ill !== 1'b1 || r_we !== 1'b0) begin errors++; $display("FAIL timeout got lat %0d ill %b we %b exp 18 1 0", lat, r_ill, r_we); end
`else
    run({7'b0, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011}, 32'h0, 100);
    checks++; if (lat !== -1) begin errors++; $display("FAIL no_timeout got wb at %0d exp none", lat); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    resp_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_addi();
    test_shift();
    test_upper();
    test_x0_illegal();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
